pio_sequencer: RTL

Table-driven master that sequences the PIO register port. The host loads a short program of steps (PIO register writes, fixed delays, input polls) through a slave register port, then starts it. The block replays the program cycle-accurately on the PIO's address/write/read interface, so bit-banged patterns run without CPU jitter. It sits between the host bus and one PIO instance and is the PIO's only bus master while busy.

---
 rtl/pio_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pio_sequencer.sv
// pio_sequencer: table-driven bus master for one PIO register port.
// The host loads a step program, then the block replays it cycle-accurately.
module pio_sequencer #(
    parameter int pSTEPS = 16,
    parameter int pPIO_ADDR_BITS = 3,
    localparam int cADDRESS_BITS = $clog2(4 + 2 * pSTEPS)
) (
    input  logic                      iCLOCK,
    input  logic                      iRESET,
    input  logic [cADDRESS_BITS-1:0]  iADDRESS,
    input  logic                      iWRITE,
    input  logic                      iREAD,
    input  logic [31:0]               iWRITE_DATA,
    output logic [31:0]               oREAD_DATA,
    output logic [pPIO_ADDR_BITS-1:0] oPIO_ADDRESS,
    output logic                      oPIO_WRITE,
    output logic                      oPIO_READ,
    output logic [31:0]               oPIO_WRITE_DATA,
    input  logic [31:0]               iPIO_READ_DATA,
    output logic                      oDONE_IRQ
);

    localparam int cSTEP_BITS = $clog2(pSTEPS);

    typedef enum logic [2:0] {
        IDLE, FETCH, WR, DLY, PREQ, PCHK, FIN
    } state_t;

    state_t state, nextState;

    logic [cSTEP_BITS-1:0]     step, stepNext;
    logic [15:0]               passCnt, passNext;
    logic [31:0]               dlyCnt, dlyNext;
    logic [31:0]               pollCnt, pollNext;
    logic [pPIO_ADDR_BITS-1:0] pioAddr, pioAddrNext;
    logic [31:0]               pioData, pioDataNext;
    logic                      doneFlag, doneNext;
    logic                      toFlag, toNext;
    logic                      abFlag, abNext;

    logic [15:0] loopReg;
    logic [31:0] toReg;
    logic [8:0]  cmdMem  [pSTEPS];
    logic [31:0] dataMem [pSTEPS];
    logic [31:0] readData, readNext;

    logic                     busy;
    logic                     ctrlWr;
    logic                     startReq;
    logic                     abortReq;
    logic                     inTable;
    logic [cADDRESS_BITS-1:0] tblOff;
    logic [cSTEP_BITS-1:0]    tblIdx;
    logic                     lastStep;
    logic                     pollHit;
    logic                     stepDone;
    logic                     passEnd;

    assign busy     = state != IDLE;
    assign ctrlWr   = iWRITE && (iADDRESS == '0);
    assign abortReq = ctrlWr && iWRITE_DATA[1];
    assign startReq = ctrlWr && iWRITE_DATA[0] && !iWRITE_DATA[1];

    // Table entries sit at 4+2k (CMD) and 5+2k (DATA).
    assign tblOff  = iADDRESS - cADDRESS_BITS'(4);
    assign tblIdx  = tblOff[cSTEP_BITS:1];
    assign inTable = (iADDRESS >= cADDRESS_BITS'(4))
                  && (tblOff[cADDRESS_BITS-1:1] < (cADDRESS_BITS-1)'(pSTEPS));

    assign lastStep = step == cSTEP_BITS'(pSTEPS - 1);
    assign pollHit  = (iPIO_READ_DATA & dataMem[step])
                   == (cmdMem[step][8] ? dataMem[step] : 32'd0);

    always_comb begin
        nextState   = state;
        stepNext    = step;
        passNext    = passCnt;
        dlyNext     = dlyCnt;
        pollNext    = pollCnt;
        pioAddrNext = pioAddr;
        pioDataNext = pioData;
        doneNext    = doneFlag;
        toNext      = toFlag;
        abNext      = abFlag;
        stepDone    = 1'b0;
        passEnd     = 1'b0;

        unique case (state)
            IDLE: begin
                if (startReq) begin
                    doneNext  = 1'b0;
                    toNext    = 1'b0;
                    abNext    = 1'b0;
                    passNext  = loopReg;
                    stepNext  = '0;
                    nextState = FETCH;
                end
            end
            FETCH: begin
                unique case (cmdMem[step][1:0])
                    2'd0: passEnd = 1'b1;
                    2'd1: begin
                        pioAddrNext = pPIO_ADDR_BITS'(cmdMem[step][6:4]);
                        pioDataNext = dataMem[step];
                        nextState   = WR;
                    end
                    2'd2: begin
                        dlyNext   = (dataMem[step] == '0) ? 32'd1 : dataMem[step];
                        nextState = DLY;
                    end
                    2'd3: begin
                        pioAddrNext = '0;
                        pollNext    = '0;
                        nextState   = PREQ;
                    end
                endcase
            end
            WR: stepDone = 1'b1;
            DLY: begin
                if (dlyCnt <= 32'd1) stepDone = 1'b1;
                else dlyNext = dlyCnt - 32'd1;
            end
            PREQ: nextState = PCHK;
            PCHK: begin
                if (pollHit) begin
                    stepDone = 1'b1;
                end else begin
                    pollNext = pollCnt + 32'd1;
                    if (toReg != '0 && pollNext == toReg) begin
                        toNext    = 1'b1;
                        nextState = FIN;
                    end else begin
                        nextState = PREQ;
                    end
                end
            end
            FIN: begin
                doneNext  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase

        if (stepDone) begin
            if (lastStep) begin
                passEnd = 1'b1;
            end else begin
                stepNext  = step + cSTEP_BITS'(1);
                nextState = FETCH;
            end
        end

        if (passEnd) begin
            if (passCnt != '0) begin
                passNext  = passCnt - 16'd1;
                stepNext  = '0;
                nextState = FETCH;
            end else begin
                nextState = FIN;
            end
        end

        // Abort freezes step so the host can see where the run stopped.
        if (abortReq && state != IDLE && state != FIN) begin
            nextState   = FIN;
            abNext      = 1'b1;
            toNext      = toFlag;
            stepNext    = step;
            passNext    = passCnt;
            pioAddrNext = pioAddr;
            pioDataNext = pioData;
        end
    end

    always_ff @(posedge iCLOCK or negedge iRESET) begin
        if (!iRESET) begin
            state    <= IDLE;
            step     <= '0;
            passCnt  <= '0;
            dlyCnt   <= '0;
            pollCnt  <= '0;
            pioAddr  <= '0;
            pioData  <= '0;
            doneFlag <= 1'b0;
            toFlag   <= 1'b0;
            abFlag   <= 1'b0;
        end else begin
            state    <= nextState;
            step     <= stepNext;
            passCnt  <= passNext;
            dlyCnt   <= dlyNext;
            pollCnt  <= pollNext;
            pioAddr  <= pioAddrNext;
            pioData  <= pioDataNext;
            doneFlag <= doneNext;
            toFlag   <= toNext;
            abFlag   <= abNext;
        end
    end

    always_comb begin
        readNext = '0;
        if (iADDRESS == '0) begin
            readNext = {16'd0, 8'(step), 4'd0, abFlag, toFlag, doneFlag, busy};
        end else if (iADDRESS == cADDRESS_BITS'(1)) begin
            readNext = {16'd0, loopReg};
        end else if (iADDRESS == cADDRESS_BITS'(2)) begin
            readNext = toReg;
        end else if (inTable) begin
            readNext = tblOff[0] ? dataMem[tblIdx] : {23'd0, cmdMem[tblIdx]};
        end
    end

    always_ff @(posedge iCLOCK or negedge iRESET) begin
        if (!iRESET) begin
            loopReg  <= '0;
            toReg    <= '0;
            readData <= '0;
            for (int i = 0; i < pSTEPS; i++) begin
                cmdMem[i]  <= '0;
                dataMem[i] <= '0;
            end
        end else begin
            if (iREAD) readData <= readNext;
            if (iWRITE && !busy) begin
                if (iADDRESS == cADDRESS_BITS'(1)) loopReg <= iWRITE_DATA[15:0];
                if (iADDRESS == cADDRESS_BITS'(2)) toReg <= iWRITE_DATA;
                if (inTable) begin
                    if (tblOff[0]) dataMem[tblIdx] <= iWRITE_DATA;
                    else cmdMem[tblIdx] <= iWRITE_DATA[8:0];
                end
            end
        end
    end

    assign oREAD_DATA      = readData;
    assign oPIO_ADDRESS    = pioAddr;
    assign oPIO_WRITE_DATA = pioData;
    assign oPIO_WRITE      = state == WR;
    assign oPIO_READ       = state == PREQ;
    assign oDONE_IRQ       = state == FIN;

endmodule
